// File: rtl/alu_pkg.sv
// Shared ALU encodings and pipeline constants for the ID/EX stage and
// the execute-stage ALU units.
package alu_pkg;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;
   localparam int OP_W   = 4;

   // ALU op[3:2]: which execute unit consumes the operands
   typedef enum logic [1:0] {
      UNIT_BITWISE = 2'b00,
      UNIT_ADDSUB  = 2'b01,
      UNIT_SHIFT   = 2'b10,
      UNIT_CMP     = 2'b11
   } unit_e;

   // ALU op[1:0] when the bitwise unit is selected
   typedef enum logic [1:0] {
      BW_AND  = 2'b00,
      BW_OR   = 2'b01,
      BW_XOR  = 2'b10,
      BW_RSVD = 2'b11
   } bw_op_e;

   // A bubble is an all-zero stage: no valid, no writeback, no load
   localparam logic [DATA_W-1:0] BUBBLE_DATA = '0;
   localparam logic [OP_W-1:0]   BUBBLE_OP   = '0;

   // The only undefined encoding is the reserved bitwise sub-op
   function automatic logic is_illegal_op(input logic [1:0] unit_sel,
                                          input logic [1:0] sub_op);
      return (unit_sel == UNIT_BITWISE) && (sub_op == BW_RSVD);
   endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass selector: picks the youngest in-flight producer of a
// register index, falling back to the register-file read value.
// Index 0 is hard-wired zero and is never bypassed.
module fwd_mux #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] idx,
   input  logic [DATA_W-1:0] rf_val,
   input  logic              exmem_reg_write,
   input  logic [REG_AW-1:0] exmem_rd_idx,
   input  logic [DATA_W-1:0] exmem_val,
   input  logic              memwb_reg_write,
   input  logic [REG_AW-1:0] memwb_rd_idx,
   input  logic [DATA_W-1:0] memwb_val,
   output logic [DATA_W-1:0] fwd_val
);

   logic idx_nz;
   logic exmem_hit;
   logic memwb_hit;

   assign idx_nz    = (idx != '0);
   assign exmem_hit = exmem_reg_write && (exmem_rd_idx == idx) && idx_nz;
   assign memwb_hit = memwb_reg_write && (memwb_rd_idx == idx) && idx_nz;

   // EX/MEM is younger than MEM/WB, so it takes priority
   always_comb begin
      fwd_val = rf_val;
      if (exmem_hit)
         fwd_val = exmem_val;
      else if (memwb_hit)
         fwd_val = memwb_val;
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the execute-stage ALU.
// Resolves register operands, selects the immediate, detects load-use
// hazards and marks the reserved bitwise op as illegal.
// Build option: define ID_EX_FWD_EN to enable the EX/MEM and MEM/WB
// bypass network and load-use detection; without it operands come
// straight from the register file and hazards are left to software.
module id_ex_stage #(
   parameter int DATA_W = alu_pkg::DATA_W,
   parameter int REG_AW = alu_pkg::REG_AW,
   parameter int OP_W   = alu_pkg::OP_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs_idx,
   input  logic [REG_AW-1:0] id_rt_idx,
   input  logic [REG_AW-1:0] id_rd_idx,
   input  logic [DATA_W-1:0] id_rs_val,
   input  logic [DATA_W-1:0] id_rt_val,
   input  logic [DATA_W-1:0] id_imm,
   input  logic              id_use_imm,
   input  logic [OP_W-1:0]   id_alu_op,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              stall,
   input  logic              flush,
   input  logic              exmem_reg_write,
   input  logic [REG_AW-1:0] exmem_rd_idx,
   input  logic [DATA_W-1:0] exmem_val,
   input  logic              memwb_reg_write,
   input  logic [REG_AW-1:0] memwb_rd_idx,
   input  logic [DATA_W-1:0] memwb_val,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [OP_W-1:0]   ex_op,
   output logic [REG_AW-1:0] ex_rd_idx,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_illegal,
   output logic              load_use_stall
);

   import alu_pkg::*;

   logic [DATA_W-1:0] rs_fwd;
   logic [DATA_W-1:0] rt_fwd;
   logic [DATA_W-1:0] b_sel;
   logic              illegal_in;
   logic              load_bubble;

   logic              vld_p1;
   logic [DATA_W-1:0] a_p1;
   logic [DATA_W-1:0] b_p1;
   logic [OP_W-1:0]   op_p1;
   logic [REG_AW-1:0] rd_p1;
   logic              reg_write_p1;
   logic              mem_read_p1;
   logic              illegal_p1;

`ifdef ID_EX_FWD_EN
   fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
      .idx             (id_rs_idx),
      .rf_val          (id_rs_val),
      .exmem_reg_write (exmem_reg_write),
      .exmem_rd_idx    (exmem_rd_idx),
      .exmem_val       (exmem_val),
      .memwb_reg_write (memwb_reg_write),
      .memwb_rd_idx    (memwb_rd_idx),
      .memwb_val       (memwb_val),
      .fwd_val         (rs_fwd)
   );

   fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
      .idx             (id_rt_idx),
      .rf_val          (id_rt_val),
      .exmem_reg_write (exmem_reg_write),
      .exmem_rd_idx    (exmem_rd_idx),
      .exmem_val       (exmem_val),
      .memwb_reg_write (memwb_reg_write),
      .memwb_rd_idx    (memwb_rd_idx),
      .memwb_val       (memwb_val),
      .fwd_val         (rt_fwd)
   );

   // A load sitting in EX cannot be bypassed yet; rt only matters when
   // it actually feeds operand B
   assign load_use_stall = vld_p1 && mem_read_p1 && (rd_p1 != '0) && id_valid &&
                           ((rd_p1 == id_rs_idx) || (!id_use_imm && (rd_p1 == id_rt_idx)));
`else
   logic unused_fwd_inputs;

   assign rs_fwd            = id_rs_val;
   assign rt_fwd            = id_rt_val;
   assign load_use_stall    = 1'b0;
   assign unused_fwd_inputs = ^{exmem_reg_write, exmem_rd_idx, exmem_val,
                                memwb_reg_write, memwb_rd_idx, memwb_val,
                                id_rs_idx, id_rt_idx};
`endif

   assign b_sel       = id_use_imm ? id_imm : rt_fwd;
   assign illegal_in  = is_illegal_op(id_alu_op[OP_W-1:OP_W-2], id_alu_op[1:0]);
   assign load_bubble = flush || (!stall && (load_use_stall || !id_valid));

   // Stage register: flush beats stall, stall holds, hazards and empty
   // decode slots insert a bubble, otherwise capture the decoded op
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1       <= 1'b0;
         a_p1         <= DATA_W'(BUBBLE_DATA);
         b_p1         <= DATA_W'(BUBBLE_DATA);
         op_p1        <= OP_W'(BUBBLE_OP);
         rd_p1        <= '0;
         reg_write_p1 <= 1'b0;
         mem_read_p1  <= 1'b0;
         illegal_p1   <= 1'b0;
      end else if (load_bubble) begin
         vld_p1       <= 1'b0;
         a_p1         <= DATA_W'(BUBBLE_DATA);
         b_p1         <= DATA_W'(BUBBLE_DATA);
         op_p1        <= OP_W'(BUBBLE_OP);
         rd_p1        <= '0;
         reg_write_p1 <= 1'b0;
         mem_read_p1  <= 1'b0;
         illegal_p1   <= 1'b0;
      end else if (!stall) begin
         vld_p1       <= 1'b1;
         a_p1         <= rs_fwd;
         b_p1         <= b_sel;
         op_p1        <= id_alu_op;
         rd_p1        <= id_rd_idx;
         reg_write_p1 <= id_reg_write && !illegal_in;
         mem_read_p1  <= id_mem_read;
         illegal_p1   <= illegal_in;
      end
   end

   assign ex_valid     = vld_p1;
   assign ex_a         = a_p1;
   assign ex_b         = b_p1;
   assign ex_op        = op_p1;
   assign ex_rd_idx    = rd_p1;
   assign ex_reg_write = reg_write_p1;
   assign ex_mem_read  = mem_read_p1;
   assign ex_illegal   = illegal_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hand-written multi-cycle
// sequences, and a randomized run against a behavioural model.
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [4:0]  id_rs_idx, id_rt_idx, id_rd_idx;
   logic [31:0] id_rs_val, id_rt_val, id_imm;
   logic        id_use_imm;
   logic [3:0]  id_alu_op;
   logic        id_reg_write, id_mem_read;
   logic        stall, flush;
   logic        exmem_reg_write;
   logic [4:0]  exmem_rd_idx;
   logic [31:0] exmem_val;
   logic        memwb_reg_write;
   logic [4:0]  memwb_rd_idx;
   logic [31:0] memwb_val;
   logic        ex_valid;
   logic [31:0] ex_a, ex_b;
   logic [3:0]  ex_op;
   logic [4:0]  ex_rd_idx;
   logic        ex_reg_write, ex_mem_read, ex_illegal;
   logic        load_use_stall;

   int checks = 0;
   int errors = 0;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs_idx(id_rs_idx), .id_rt_idx(id_rt_idx), .id_rd_idx(id_rd_idx),
      .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
      .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .stall(stall), .flush(flush),
      .exmem_reg_write(exmem_reg_write), .exmem_rd_idx(exmem_rd_idx), .exmem_val(exmem_val),
      .memwb_reg_write(memwb_reg_write), .memwb_rd_idx(memwb_rd_idx), .memwb_val(memwb_val),
      .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_op(ex_op),
      .ex_rd_idx(ex_rd_idx), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_illegal(ex_illegal), .load_use_stall(load_use_stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      id_valid = 1'b0; id_rs_idx = '0; id_rt_idx = '0; id_rd_idx = '0;
      id_rs_val = '0; id_rt_val = '0; id_imm = '0; id_use_imm = 1'b0;
      id_alu_op = '0; id_reg_write = 1'b0; id_mem_read = 1'b0;
      stall = 1'b0; flush = 1'b0;
      exmem_reg_write = 1'b0; exmem_rd_idx = '0; exmem_val = '0;
      memwb_reg_write = 1'b0; memwb_rd_idx = '0; memwb_val = '0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic v; logic [4:0] rs, rt, rd; logic [31:0] rsv, rtv, imm;
      logic ui; logic [3:0] op; logic rw;
      logic exw; logic [4:0] exrd; logic [31:0] exv;
      logic mww; logic [4:0] mwrd; logic [31:0] mwv;
      logic [31:0] ea, eb; logic evld, erw, eill;
   } vec_t;

   vec_t tbl [9];

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic v; logic [31:0] a, b; logic [3:0] op; logic [4:0] rd;
      logic rw, mr, ill;
   } st_t;

   st_t m, m_next;

   function automatic logic [31:0] ref_fwd(input logic [4:0] idx, input logic [31:0] rf);
      if (!FWD || idx == 5'd0) return rf;
      if (exmem_reg_write && exmem_rd_idx == idx) return exmem_val;
      if (memwb_reg_write && memwb_rd_idx == idx) return memwb_val;
      return rf;
   endfunction

   function automatic logic ref_lus(input st_t cur);
      if (!FWD) return 1'b0;
      return cur.v && cur.mr && cur.rd != 5'd0 && id_valid &&
             (cur.rd == id_rs_idx || (!id_use_imm && cur.rd == id_rt_idx));
   endfunction

   function automatic st_t ref_next(input st_t cur);
      st_t n;
      logic bad;
      n = '0;
      if (flush) return n;
      if (stall) return cur;
      if (ref_lus(cur) || !id_valid) return n;
      bad   = (id_alu_op == 4'b0011);
      n.v   = 1'b1;
      n.a   = ref_fwd(id_rs_idx, id_rs_val);
      n.b   = id_use_imm ? id_imm : ref_fwd(id_rt_idx, id_rt_val);
      n.op  = id_alu_op;
      n.rd  = id_rd_idx;
      n.rw  = id_reg_write && !bad;
      n.mr  = id_mem_read;
      n.ill = bad;
      return n;
   endfunction

   initial begin
      // v rs rt rd rsv rtv imm ui op rw | exw exrd exv | mww mwrd mwv | ea eb evld erw eill
      tbl[0] = '{1'b1, 5'd1, 5'd2, 5'd3, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'h0, 1'b0, 4'b0000, 1'b1,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                 32'hFFFFFFFF, 32'hF0F0F0F0, 1'b1, 1'b1, 1'b0};
      tbl[1] = '{1'b1, 5'd5, 5'd0, 5'd4, 32'hAAAA0000, 32'h0, 32'h0, 1'b0, 4'b0100, 1'b1,
                 1'b1, 5'd5, 32'h00000001, 1'b1, 5'd5, 32'h00000002,
                 FWD ? 32'h00000001 : 32'hAAAA0000, 32'h0, 1'b1, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 5'd5, 5'd0, 5'd4, 32'hAAAA0000, 32'h0, 32'h0, 1'b0, 4'b0100, 1'b1,
                 1'b0, 5'd5, 32'h00000001, 1'b1, 5'd5, 32'h00000002,
                 FWD ? 32'h00000002 : 32'hAAAA0000, 32'h0, 1'b1, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 5'd0, 5'd0, 5'd4, 32'h12345678, 32'h9ABCDEF0, 32'h0, 1'b0, 4'b1000, 1'b1,
                 1'b1, 5'd0, 32'h00000001, 1'b1, 5'd0, 32'h00000002,
                 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 5'd1, 5'd6, 5'd8, 32'h11111111, 32'h22222222, 32'h0000FFFF, 1'b1, 4'b0101, 1'b1,
                 1'b1, 5'd6, 32'h55555555, 1'b0, 5'd0, 32'h0,
                 32'h11111111, 32'h0000FFFF, 1'b1, 1'b1, 1'b0};
      tbl[5] = '{1'b1, 5'd1, 5'd6, 5'd8, 32'h11111111, 32'h22222222, 32'h0000FFFF, 1'b0, 4'b1100, 1'b1,
                 1'b0, 5'd6, 32'h55555555, 1'b1, 5'd6, 32'h0BADF00D,
                 32'h11111111, FWD ? 32'h0BADF00D : 32'h22222222, 1'b1, 1'b1, 1'b0};
      tbl[6] = '{1'b1, 5'd2, 5'd3, 5'd9, 32'hCAFEBABE, 32'h01010101, 32'h0, 1'b0, 4'b0011, 1'b1,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                 32'hCAFEBABE, 32'h01010101, 1'b1, 1'b0, 1'b1};
      tbl[7] = '{1'b0, 5'd2, 5'd3, 5'd9, 32'hCAFEBABE, 32'h01010101, 32'h0, 1'b0, 4'b0101, 1'b1,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
      tbl[8] = '{1'b1, 5'd2, 5'd3, 5'd9, 32'h0000ABCD, 32'h00001234, 32'h0, 1'b0, 4'b0111, 1'b1,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                 32'h0000ABCD, 32'h00001234, 1'b1, 1'b1, 1'b0};

      drive_idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", 128'({ex_valid, ex_a, ex_b, ex_op, ex_rd_idx, ex_reg_write, ex_mem_read, ex_illegal}), 128'(0));
      chk("reset_lus", 128'(load_use_stall), 128'(0));
      @(negedge clk);
      rst = 1'b0;

      // ---- table ----
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         id_valid = tbl[i].v; id_rs_idx = tbl[i].rs; id_rt_idx = tbl[i].rt; id_rd_idx = tbl[i].rd;
         id_rs_val = tbl[i].rsv; id_rt_val = tbl[i].rtv; id_imm = tbl[i].imm;
         id_use_imm = tbl[i].ui; id_alu_op = tbl[i].op; id_reg_write = tbl[i].rw; id_mem_read = 1'b0;
         exmem_reg_write = tbl[i].exw; exmem_rd_idx = tbl[i].exrd; exmem_val = tbl[i].exv;
         memwb_reg_write = tbl[i].mww; memwb_rd_idx = tbl[i].mwrd; memwb_val = tbl[i].mwv;
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d_a", i), 128'(ex_a), 128'(tbl[i].ea));
         chk($sformatf("tbl%0d_b", i), 128'(ex_b), 128'(tbl[i].eb));
         chk($sformatf("tbl%0d_valid", i), 128'(ex_valid), 128'(tbl[i].evld));
         chk($sformatf("tbl%0d_rw", i), 128'(ex_reg_write), 128'(tbl[i].erw));
         chk($sformatf("tbl%0d_ill", i), 128'(ex_illegal), 128'(tbl[i].eill));
         chk($sformatf("tbl%0d_op", i), 128'(ex_op), 128'(tbl[i].evld ? tbl[i].op : 4'b0000));
         chk($sformatf("tbl%0d_rd", i), 128'(ex_rd_idx), 128'(tbl[i].evld ? tbl[i].rd : 5'd0));
         chk($sformatf("tbl%0d_mr", i), 128'(ex_mem_read), 128'(0));
      end

      // ---- load-use ----
      @(negedge clk);
      drive_idle();
      id_valid = 1'b1; id_rs_idx = 5'd1; id_rt_idx = 5'd2; id_rd_idx = 5'd7;
      id_alu_op = 4'b0100; id_reg_write = 1'b1; id_mem_read = 1'b1;
      @(posedge clk);
      #1;
      chk("lu_load_captured", 128'({ex_valid, ex_mem_read, ex_rd_idx}), 128'({1'b1, 1'b1, 5'd7}));
      @(negedge clk);
      drive_idle();
      id_valid = 1'b1; id_rs_idx = 5'd7; id_rt_idx = 5'd3; id_rd_idx = 5'd8;
      id_rs_val = 32'h00000077; id_alu_op = 4'b0000; id_reg_write = 1'b1;
      #1;
      chk("lu_stall_req", 128'(load_use_stall), 128'(FWD));
      @(posedge clk);
      #1;
      chk("lu_bubble_valid", 128'(ex_valid), 128'(!FWD));
      chk("lu_bubble_a", 128'(ex_a), 128'(FWD ? 32'h0 : 32'h00000077));

      // ---- stall / flush ----
      @(negedge clk);
      drive_idle();
      id_valid = 1'b1; id_rs_idx = 5'd1; id_rt_idx = 5'd2; id_rd_idx = 5'd9;
      id_rs_val = 32'h13579BDF; id_rt_val = 32'h2468ACE0; id_alu_op = 4'b0101; id_reg_write = 1'b1;
      @(posedge clk);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         stall = 1'b1;
         id_rs_val = 32'hDEAD0000 + 32'(c); id_rt_val = 32'hBEEF0000; id_alu_op = 4'b1111;
         @(posedge clk);
         #1;
         chk($sformatf("stall%0d_hold", c),
             128'({ex_valid, ex_a, ex_b, ex_op, ex_rd_idx, ex_reg_write}),
             128'({1'b1, 32'h13579BDF, 32'h2468ACE0, 4'b0101, 5'd9, 1'b1}));
      end
      @(negedge clk);
      stall = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1;
      chk("stall_flush_bubble",
          128'({ex_valid, ex_a, ex_b, ex_op, ex_rd_idx, ex_reg_write, ex_mem_read, ex_illegal}), 128'(0));

      // ---- async reset mid-cycle ----
      @(negedge clk);
      drive_idle();
      id_valid = 1'b1; id_rs_val = 32'h0F0F0F0F; id_rd_idx = 5'd4; id_alu_op = 4'b0011; id_mem_read = 1'b1;
      @(posedge clk);
      #1;
      chk("pre_reset_captured", 128'({ex_valid, ex_illegal, ex_a}), 128'({1'b1, 1'b1, 32'h0F0F0F0F}));
      #2;
      rst = 1'b1;
      #1;
      chk("async_reset_clear",
          128'({ex_valid, ex_a, ex_b, ex_op, ex_rd_idx, ex_reg_write, ex_mem_read, ex_illegal}), 128'(0));

      // ---- randomized run against the model ----
      @(negedge clk);
      drive_idle();
      rst = 1'b0;
      m = '0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         id_valid        = ($urandom_range(0, 3) != 0);
         id_rs_idx       = 5'($urandom_range(0, 7));
         id_rt_idx       = 5'($urandom_range(0, 7));
         id_rd_idx       = 5'($urandom_range(0, 7));
         id_rs_val       = $urandom;
         id_rt_val       = $urandom;
         id_imm          = $urandom;
         id_use_imm      = 1'($urandom_range(0, 1));
         id_alu_op       = 4'($urandom_range(0, 15));
         id_reg_write    = 1'($urandom_range(0, 1));
         id_mem_read     = ($urandom_range(0, 2) == 0);
         stall           = ($urandom_range(0, 7) == 0);
         flush           = ($urandom_range(0, 15) == 0);
         exmem_reg_write = 1'($urandom_range(0, 1));
         exmem_rd_idx    = 5'($urandom_range(0, 7));
         exmem_val       = $urandom;
         memwb_reg_write = 1'($urandom_range(0, 1));
         memwb_rd_idx    = 5'($urandom_range(0, 7));
         memwb_val       = $urandom;
         #1;
         chk($sformatf("rnd%0d_lus", n), 128'(load_use_stall), 128'(ref_lus(m)));
         m_next = ref_next(m);
         @(posedge clk);
         #1;
         m = m_next;
         chk($sformatf("rnd%0d_out", n),
             128'({ex_valid, ex_a, ex_b, ex_op, ex_rd_idx, ex_reg_write, ex_mem_read, ex_illegal}),
             128'(m));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
